// File: rtl/ro_meas_pkg.sv
// Shared state encodings and channel indices for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_RUN  = 3'd2;
  localparam state_t ST_POST = 3'd3;
  localparam state_t ST_CAP  = 3'd4;
  localparam state_t ST_DONE = 3'd5;

  localparam logic CH_SHORT = 1'b0;
  localparam logic CH_LONG  = 1'b1;

  // Short RO always goes first when it is selected.
  function automatic logic first_ch(input logic [1:0] mask);
    return mask[0] ? CH_SHORT : CH_LONG;
  endfunction

endpackage

// File: rtl/ro_meas_chan.sv
// One RO measurement channel: start/end snapshots, modular delta, band check and sticky alarm.
module ro_meas_chan
  import ro_meas_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  input  logic [CNT_W-1:0] ro_cnt,
  input  logic             latch_start,
  input  logic             latch_end,
  input  logic             capture,
  input  logic             alarm_clr,
  input  logic [CNT_W-1:0] thr_lo,
  input  logic [CNT_W-1:0] thr_hi,
  output logic [CNT_W-1:0] res,
  output logic             res_vld,
  output logic             alarm
);

  logic [CNT_W-1:0] cnt_start;
  logic [CNT_W-1:0] cnt_end;
  logic [CNT_W-1:0] delta;
  logic             out_of_band;

  // Counter wrap between snapshots is legal, so plain modular subtraction is the delta.
  assign delta       = cnt_end - cnt_start;
  assign out_of_band = (delta < thr_lo) || (delta > thr_hi);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      cnt_start <= '0;
      cnt_end   <= '0;
      res       <= '0;
      res_vld   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      res_vld <= capture;
      if (latch_start) cnt_start <= ro_cnt;
      if (latch_end)   cnt_end   <= ro_cnt;
      if (capture)     res       <= delta;
      // A new out-of-band result beats a simultaneous clear.
      if (capture && out_of_band) alarm <= 1'b1;
      else if (alarm_clr)         alarm <= 1'b0;
    end
  end

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator measurement sequencer: gates RO enables, snapshots counters, publishes deltas.
// Optional level interrupt on any sticky alarm when RO_MEAS_IRQ_EN is defined.
module ro_meas_sched
  import ro_meas_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 3
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic             cfg_cont,
  input  logic [1:0]       cfg_ch_mask,
  input  logic [WIN_W-1:0] cfg_win,
  input  logic [CNT_W-1:0] cfg_thr_lo,
  input  logic [CNT_W-1:0] cfg_thr_hi,
  input  logic [1:0]       alarm_clr,
  input  logic [CNT_W-1:0] ro_short_cnt,
  input  logic [CNT_W-1:0] ro_long_cnt,
  output logic             ro_short_en,
  output logic             ro_long_en,
  output logic [CNT_W-1:0] res_short,
  output logic [CNT_W-1:0] res_long,
  output logic [1:0]       res_vld,
  output logic             seq_done,
  output logic             busy,
  output logic [1:0]       alarm
`ifdef RO_MEAS_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int SW = $clog2(SETTLE_CYC);

  state_t           state;
  logic             cur_ch;
  logic [1:0]       mask_q;
  logic [SW-1:0]    settle_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic             settle_last;
  logic             latch_start;
  logic             latch_end;
  logic             capture;

  assign settle_last = (settle_cnt == SW'(SETTLE_CYC - 1));
  assign latch_start = (state == ST_PRE)  && settle_last && !cfg_stop;
  assign latch_end   = (state == ST_POST) && settle_last && !cfg_stop;
  assign capture     = (state == ST_CAP)  && !cfg_stop;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state      <= ST_IDLE;
      cur_ch     <= CH_SHORT;
      mask_q     <= 2'b00;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else if (cfg_stop) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      win_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cfg_start && (|cfg_ch_mask)) begin
          state      <= ST_PRE;
          mask_q     <= cfg_ch_mask;
          cur_ch     <= first_ch(cfg_ch_mask);
          settle_cnt <= '0;
        end
        ST_PRE: if (settle_last) begin
          settle_cnt <= '0;
          // A zero window still runs the RO for one cycle.
          win_cnt    <= (cfg_win == '0) ? '0 : cfg_win - WIN_W'(1);
          state      <= ST_RUN;
        end else begin
          settle_cnt <= settle_cnt + SW'(1);
        end
        ST_RUN: if (win_cnt == '0) state <= ST_POST;
                else               win_cnt <= win_cnt - WIN_W'(1);
        ST_POST: if (settle_last) begin
          settle_cnt <= '0;
          state      <= ST_CAP;
        end else begin
          settle_cnt <= settle_cnt + SW'(1);
        end
        ST_CAP: if ((cur_ch == CH_SHORT) && mask_q[1]) begin
          cur_ch <= CH_LONG;
          state  <= ST_PRE;
        end else begin
          state <= ST_DONE;
        end
        ST_DONE: if (cfg_cont && (|cfg_ch_mask)) begin
          state      <= ST_PRE;
          mask_q     <= cfg_ch_mask;
          cur_ch     <= first_ch(cfg_ch_mask);
          settle_cnt <= '0;
        end else begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ro_short_en = (state == ST_RUN) && (cur_ch == CH_SHORT);
  assign ro_long_en  = (state == ST_RUN) && (cur_ch == CH_LONG);
  assign seq_done    = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);

  ro_meas_chan #(.CNT_W(CNT_W)) u_chan_short (
    .mclk        (mclk),
    .puc_rst_n   (puc_rst_n),
    .ro_cnt      (ro_short_cnt),
    .latch_start (latch_start && (cur_ch == CH_SHORT)),
    .latch_end   (latch_end && (cur_ch == CH_SHORT)),
    .capture     (capture && (cur_ch == CH_SHORT)),
    .alarm_clr   (alarm_clr[0]),
    .thr_lo      (cfg_thr_lo),
    .thr_hi      (cfg_thr_hi),
    .res         (res_short),
    .res_vld     (res_vld[0]),
    .alarm       (alarm[0])
  );

  ro_meas_chan #(.CNT_W(CNT_W)) u_chan_long (
    .mclk        (mclk),
    .puc_rst_n   (puc_rst_n),
    .ro_cnt      (ro_long_cnt),
    .latch_start (latch_start && (cur_ch == CH_LONG)),
    .latch_end   (latch_end && (cur_ch == CH_LONG)),
    .capture     (capture && (cur_ch == CH_LONG)),
    .alarm_clr   (alarm_clr[1]),
    .thr_lo      (cfg_thr_lo),
    .thr_hi      (cfg_thr_hi),
    .res         (res_long),
    .res_vld     (res_vld[1]),
    .alarm       (alarm[1])
  );

`ifdef RO_MEAS_IRQ_EN
  assign irq = |alarm;
`endif

endmodule

// File: tb/tb_ro_meas_sched.sv
// Directed bench for ro_meas_sched with a behavioural RO model (+1 count per 4 enabled mclk cycles).
module tb_ro_meas_sched;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic        cfg_cont = 1'b0;
  logic [1:0]  cfg_ch_mask = 2'b00;
  logic [15:0] cfg_win = '0;
  logic [15:0] cfg_thr_lo = '0;
  logic [15:0] cfg_thr_hi = '0;
  logic [1:0]  alarm_clr = 2'b00;
  logic [15:0] ro_short_cnt = '0;
  logic [15:0] ro_long_cnt = '0;
  logic        ro_short_en;
  logic        ro_long_en;
  logic [15:0] res_short;
  logic [15:0] res_long;
  logic [1:0]  res_vld;
  logic        seq_done;
  logic        busy;
  logic [1:0]  alarm;
`ifdef RO_MEAS_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad = 0;
  int sh_en_cyc, lg_en_cyc, overlap_cyc, vld0_cnt, vld1_cnt, done_cnt;
  int div_s, div_l;

  always #5 mclk = ~mclk;

  ro_meas_sched #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(3)) dut (
    .mclk         (mclk),
    .puc_rst_n    (puc_rst_n),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_cont     (cfg_cont),
    .cfg_ch_mask  (cfg_ch_mask),
    .cfg_win      (cfg_win),
    .cfg_thr_lo   (cfg_thr_lo),
    .cfg_thr_hi   (cfg_thr_hi),
    .alarm_clr    (alarm_clr),
    .ro_short_cnt (ro_short_cnt),
    .ro_long_cnt  (ro_long_cnt),
    .ro_short_en  (ro_short_en),
    .ro_long_en   (ro_long_en),
    .res_short    (res_short),
    .res_long     (res_long),
    .res_vld      (res_vld),
    .seq_done     (seq_done),
    .busy         (busy),
    .alarm        (alarm)
`ifdef RO_MEAS_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then run the RO model and the activity counters.
  task automatic step();
    @(negedge mclk);
    if (ro_short_en) begin
      sh_en_cyc++;
      div_s++;
      if (div_s == 4) begin div_s = 0; ro_short_cnt = ro_short_cnt + 16'd1; end
    end
    if (ro_long_en) begin
      lg_en_cyc++;
      div_l++;
      if (div_l == 4) begin div_l = 0; ro_long_cnt = ro_long_cnt + 16'd1; end
    end
    if (ro_short_en && ro_long_en) overlap_cyc++;
    if (res_vld[0]) vld0_cnt++;
    if (res_vld[1]) vld1_cnt++;
    if (seq_done) done_cnt++;
  endtask

  task automatic clearStats();
    sh_en_cyc = 0; lg_en_cyc = 0; overlap_cyc = 0;
    vld0_cnt = 0; vld1_cnt = 0; done_cnt = 0;
    div_s = 0; div_l = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] mask, input logic [15:0] win,
                               input logic [15:0] lo, input logic [15:0] hi, input logic cont);
    cfg_ch_mask = mask; cfg_win = win; cfg_thr_lo = lo; cfg_thr_hi = hi; cfg_cont = cont;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!seq_done && n < budget) begin step(); n++; end
    checkOutput({tag, "_seq_done_seen"}, 32'(seq_done), 32'd1);
  endtask

  initial begin
    int n;
    clearStats();

    // Reset state
    repeat (3) step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_en", {30'd0, ro_long_en, ro_short_en}, 32'd0);
    checkOutput("rst_res", {res_long, res_short}, 32'd0);
    checkOutput("rst_vld_alarm", {28'd0, res_vld, alarm}, 32'd0);
    checkOutput("rst_seq_done", 32'(seq_done), 32'd0);
    puc_rst_n = 1'b1;
    repeat (2) step();

    // Short only, 100-cycle window: 25 counts, inside 20..30
    clearStats();
    applyStimulus(2'b01, 16'd100, 16'd20, 16'd30, 1'b0);
    waitDone("t1", 400);
    repeat (2) step();
    checkOutput("t1_res_short", 32'(res_short), 32'd25);
    checkOutput("t1_vld_cnt", 32'(vld0_cnt * 16 + vld1_cnt), 32'd16);
    checkOutput("t1_alarm", 32'(alarm), 32'd0);
    checkOutput("t1_en_cycles", 32'(sh_en_cyc * 1000 + lg_en_cyc), 32'd100000);
    checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);

    // Both channels, 10-cycle windows, never overlapping
    clearStats();
    ro_short_cnt = 16'd0; ro_long_cnt = 16'd0;
    applyStimulus(2'b11, 16'd10, 16'd0, 16'd30, 1'b0);
    waitDone("t2", 400);
    repeat (2) step();
    checkOutput("t2_short_en_cyc", 32'(sh_en_cyc), 32'd10);
    checkOutput("t2_long_en_cyc", 32'(lg_en_cyc), 32'd10);
    checkOutput("t2_overlap", 32'(overlap_cyc), 32'd0);
    checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("t2_res", {res_long, res_short}, {16'd2, 16'd2});
    checkOutput("t2_vld_cnt", 32'(vld0_cnt * 16 + vld1_cnt), 32'd17);
    checkOutput("t2_alarm", 32'(alarm), 32'd0);

    // Counter wraps from 0xFFF0 through zero: delta 0x10
    clearStats();
    ro_short_cnt = 16'hFFF0;
    applyStimulus(2'b01, 16'd64, 16'h0008, 16'h0018, 1'b0);
    waitDone("t3", 400);
    repeat (2) step();
    checkOutput("t3_res_short", 32'(res_short), 32'h10);
    checkOutput("t3_alarm", 32'(alarm), 32'd0);

    // Abort in the middle of the short window
    clearStats();
    applyStimulus(2'b11, 16'd200, 16'd0, 16'd30, 1'b0);
    n = 0;
    while (!ro_short_en && n < 20) begin step(); n++; end
    checkOutput("t4_run_seen", 32'(ro_short_en), 32'd1);
    repeat (5) step();
    cfg_stop = 1'b1;
    step();
    cfg_stop = 1'b0;
    checkOutput("t4_en_after_stop", {30'd0, ro_long_en, ro_short_en}, 32'd0);
    checkOutput("t4_busy_after_stop", 32'(busy), 32'd0);
    repeat (20) step();
    checkOutput("t4_res_kept", {res_long, res_short}, {16'd2, 16'h10});
    checkOutput("t4_no_vld_done", 32'(vld0_cnt + vld1_cnt + done_cnt), 32'd0);
    cfg_start = 1'b1; cfg_stop = 1'b1;
    step();
    cfg_start = 1'b0; cfg_stop = 1'b0;
    checkOutput("t4_stop_beats_start", 32'(busy), 32'd0);

    // Delta 5 below 20..30 raises the short alarm
    clearStats();
    applyStimulus(2'b01, 16'd20, 16'd20, 16'd30, 1'b0);
    waitDone("t5", 400);
    repeat (2) step();
    checkOutput("t5_res_short", 32'(res_short), 32'd5);
    checkOutput("t5_alarm", 32'(alarm), 32'd1);
`ifdef RO_MEAS_IRQ_EN
    checkOutput("t5_irq", 32'(irq), 32'd1);
`endif
    alarm_clr = 2'b01;
    step();
    alarm_clr = 2'b00;
    checkOutput("t5_alarm_cleared", 32'(alarm), 32'd0);
`ifdef RO_MEAS_IRQ_EN
    checkOutput("t5_irq_cleared", 32'(irq), 32'd0);
`endif
    // Clear held across a new out-of-band capture: the set wins
    clearStats();
    alarm_clr = 2'b01;
    applyStimulus(2'b01, 16'd20, 16'd20, 16'd30, 1'b0);
    n = 0;
    while (!res_vld[0] && n < 100) begin step(); n++; end
    checkOutput("t5_vld_seen", 32'(res_vld[0]), 32'd1);
    checkOutput("t5_set_beats_clr", 32'(alarm[0]), 32'd1);
    alarm_clr = 2'b00;
    step();
    checkOutput("t5_alarm_sticky", 32'(alarm[0]), 32'd1);
    repeat (2) step();

    // Continuous mode with a zero window: one pass every 9 cycles
    clearStats();
    applyStimulus(2'b01, 16'd0, 16'd0, 16'hFFFF, 1'b1);
    waitDone("t6", 100);
    n = 0;
    begin
      int busy_low = 0;
      do begin
        step();
        n++;
        if (!busy) busy_low++;
      end while (!seq_done && n < 50);
      checkOutput("t6_pass_period", 32'(n), 32'd9);
      checkOutput("t6_busy_held", 32'(busy_low), 32'd0);
    end
    n = 0;
    do begin step(); n++; end while (!ro_short_en && n < 20);
    checkOutput("t6_run_seen", 32'(ro_short_en), 32'd1);
    #2 puc_rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_en", {30'd0, ro_long_en, ro_short_en}, 32'd0);
    checkOutput("t6_rst_busy_done", {30'd0, busy, seq_done}, 32'd0);
    checkOutput("t6_rst_res", {res_long, res_short}, 32'd0);
    checkOutput("t6_rst_vld_alarm", {28'd0, res_vld, alarm}, 32'd0);
    cfg_cont = 1'b0;
    repeat (2) step();
    puc_rst_n = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
